// File: rtl/fetch_ctrl_if.sv
// Fetch controller handshake bundle: hazard/branch/memory inputs and PC-control outputs.
// master = the controller, slave = the surrounding pipeline and instruction memory.
interface fetch_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stall_D;
    logic             branch_taken;
    logic             imem_ack;
    logic             imem_req;
    logic             pc_enable;
    logic             pcsrc_out;
    logic             instr_valid_F;
    logic             flush_D;
    logic             imem_err;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  stall_D, branch_taken, imem_ack,
        output imem_req, pc_enable, pcsrc_out, instr_valid_F, flush_D, imem_err, fetch_count
    );

    modport slave (
        output stall_D, branch_taken, imem_ack,
        input  imem_req, pc_enable, pcsrc_out, instr_valid_F, flush_D, imem_err, fetch_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC enable/select are same-cycle (Mealy) from state and inputs; imem_req is Moore.
// Decode stall holds the delivered word in HOLD; no ack within MAX_WAIT wait cycles latches imem_err.
module fetch_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t           r_state;
    logic [WW-1:0]    r_wcnt;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic w_pc_en;
    logic w_pcsrc;
    logic w_flush;
    logic w_vld;
    logic w_deliver;
    logic w_timeout;

    assign w_timeout = (r_wcnt == WW'(MAX_WAIT));

    always_comb begin
        w_pc_en   = 1'b0;
        w_pcsrc   = 1'b0;
        w_flush   = 1'b0;
        w_vld     = 1'b0;
        w_deliver = 1'b0;
        if (reset) begin
            case (r_state)
                REQ: begin
                    if (bus.branch_taken) begin
                        w_pc_en = 1'b1;
                        w_pcsrc = 1'b1;
                        w_flush = 1'b1;
                    end else if (bus.imem_ack) begin
                        w_vld     = 1'b1;
                        w_pc_en   = !bus.stall_D;
                        w_deliver = !bus.stall_D;
                    end
                end
                HOLD: begin
                    // The held word stays valid on the bus until it is consumed or squashed.
                    w_vld = 1'b1;
                    if (bus.branch_taken) begin
                        w_pc_en = 1'b1;
                        w_pcsrc = 1'b1;
                        w_flush = 1'b1;
                    end else if (!bus.stall_D) begin
                        w_pc_en   = 1'b1;
                        w_deliver = 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.branch_taken) begin
                        w_pc_en = 1'b1;
                        w_pcsrc = 1'b1;
                        w_flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_deliver) begin
                r_count <= r_count + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                    r_wcnt  <= '0;
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        r_wcnt <= '0;
                        if (!bus.branch_taken && bus.stall_D) begin
                            r_state <= HOLD;
                        end
                    end else if (w_timeout) begin
                        r_state <= ERROR;
                        r_err   <= 1'b1;
                    end else begin
                        // A redirect without ack leaves the request in flight; keep timing it.
                        r_wcnt <= r_wcnt + 1'b1;
                        if (bus.branch_taken) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                HOLD: begin
                    if (bus.branch_taken || !bus.stall_D) begin
                        r_state <= REQ;
                    end
                end
                DRAIN: begin
                    if (bus.imem_ack) begin
                        r_state <= REQ;
                        r_wcnt  <= '0;
                    end else if (w_timeout) begin
                        r_state <= ERROR;
                        r_err   <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: r_state <= ERROR;
            endcase
        end
    end

    assign bus.imem_req      = reset && (r_state == REQ);
    assign bus.pc_enable     = w_pc_en;
    assign bus.pcsrc_out     = w_pcsrc;
    assign bus.flush_D       = w_flush;
    assign bus.instr_valid_F = w_vld;
    assign bus.imem_err      = r_err;
    assign bus.fetch_count   = r_count;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table for the main flows plus hand sequences
// for timeout, counter wrap and reset during HOLD.
module tb_fetch_ctrl;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;

    logic clk = 1'b0;
    logic reset;

    fetch_ctrl_if #(.CNT_W(CNT_W)) bus ();

    fetch_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected word layout: {req, pc_en, pcsrc, vld, flush, err, count[3:0]}
    typedef struct {
        logic       rst_n;
        logic       br;
        logic       ack;
        logic       stall;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[23];

    function automatic logic [9:0] e(input logic req, input logic pe, input logic src,
                                     input logic vld, input logic fl, input logic err,
                                     input int cnt);
        logic [3:0] c;
        c = 4'(cnt);
        return {req, pe, src, vld, fl, err, c};
    endfunction

    function automatic vec_t v(input logic r, input logic b, input logic a, input logic s,
                               input logic [9:0] x);
        vec_t t;
        t.rst_n = r;
        t.br    = b;
        t.ack   = a;
        t.stall = s;
        t.exp   = x;
        return t;
    endfunction

    task automatic apply(input logic r, input logic b, input logic a, input logic s);
        @(negedge clk);
        reset            = r;
        bus.branch_taken = b;
        bus.imem_ack     = a;
        bus.stall_D      = s;
        #1;
    endtask

    task automatic check(input string name, input logic [9:0] exp, input logic [9:0] mask);
        logic [9:0] act;
        act = {bus.imem_req, bus.pc_enable, bus.pcsrc_out, bus.instr_valid_F,
               bus.flush_D, bus.imem_err, bus.fetch_count};
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            errors++;
            $display("FAIL %s: got %b required %b (req,pe,src,vld,fl,err,cnt)",
                     name, act & mask, exp & mask);
        end
    endtask

    initial begin
        reset            = 1'b0;
        bus.branch_taken = 1'b0;
        bus.imem_ack     = 1'b0;
        bus.stall_D      = 1'b0;

        vecs[0]  = v(0, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 0));
        vecs[1]  = v(1, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            vecs[2 + k] = v(1, 0, 1, 0, e(1, 1, 0, 1, 0, 0, k));
        vecs[7]  = v(1, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 5));
        vecs[8]  = v(1, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 5));
        vecs[9]  = v(1, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 5));
        vecs[10] = v(1, 0, 1, 1, e(1, 0, 0, 1, 0, 0, 5));
        vecs[11] = v(1, 0, 0, 1, e(0, 0, 0, 1, 0, 0, 5));
        vecs[12] = v(1, 0, 0, 1, e(0, 0, 0, 1, 0, 0, 5));
        vecs[13] = v(1, 0, 0, 0, e(0, 1, 0, 1, 0, 0, 5));
        vecs[14] = v(1, 1, 0, 0, e(1, 1, 1, 0, 1, 0, 6));
        vecs[15] = v(1, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 6));
        vecs[16] = v(1, 1, 0, 0, e(0, 1, 1, 0, 1, 0, 6));
        vecs[17] = v(1, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 6));
        vecs[18] = v(1, 1, 1, 0, e(1, 1, 1, 0, 1, 0, 6));
        vecs[19] = v(1, 0, 1, 0, e(1, 1, 0, 1, 0, 0, 6));
        vecs[20] = v(1, 0, 1, 1, e(1, 0, 0, 1, 0, 0, 7));
        vecs[21] = v(1, 1, 1, 1, e(0, 1, 1, 1, 1, 0, 7));
        vecs[22] = v(1, 0, 1, 0, e(1, 1, 0, 1, 0, 0, 7));

        for (int i = 0; i < 23; i++) begin
            apply(vecs[i].rst_n, vecs[i].br, vecs[i].ack, vecs[i].stall);
            check($sformatf("vec%0d", i), vecs[i].exp, 10'h3FF);
        end

        // Timeout: 16 REQ cycles without ack are tolerated, then ERROR.
        for (int k = 0; k < MAX_WAIT + 1; k++) begin
            apply(1, 0, 0, 0);
            check($sformatf("wait%0d", k), e(1, 0, 0, 0, 0, 0, 8), 10'h3FF);
        end
        for (int k = 0; k < 3; k++) begin
            apply(1, 1, 1, (k == 1));
            check($sformatf("error%0d", k), e(0, 0, 0, 0, 0, 1, 8), 10'h3FF);
        end
        apply(0, 1, 1, 0);
        check("err_reset_comb", e(0, 0, 0, 0, 0, 0, 0), 10'b11111_00000);
        apply(1, 0, 0, 0);
        check("err_cleared_idle", e(0, 0, 0, 0, 0, 0, 0), 10'h3FF);

        // Counter wrap with a 4-bit count: 17 deliveries leave 1.
        for (int k = 0; k < 17; k++) begin
            apply(1, 0, 1, 0);
            check($sformatf("wrap%0d", k), e(1, 1, 0, 1, 0, 0, k % 16), 10'h3FF);
        end
        apply(1, 0, 1, 1);
        check("wrap_to_hold", e(1, 0, 0, 1, 0, 0, 1), 10'h3FF);
        apply(1, 0, 0, 1);
        check("hold_wrapped", e(0, 0, 0, 1, 0, 0, 1), 10'h3FF);

        // Reset in the middle of HOLD.
        apply(0, 0, 0, 1);
        check("hold_reset_comb", e(0, 0, 0, 0, 0, 0, 0), 10'b11111_10000);
        apply(0, 0, 1, 0);
        check("hold_reset_state", e(0, 0, 0, 0, 0, 0, 0), 10'h3FF);
        apply(1, 0, 1, 0);
        check("post_reset_idle", e(0, 0, 0, 0, 0, 0, 0), 10'h3FF);
        apply(1, 0, 1, 0);
        check("post_reset_req", e(1, 1, 0, 1, 0, 0, 0), 10'h3FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
